// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier control path.
// The sequencer state encoding and the Booth pair decode live here.
package booth_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  // Booth pair {B[0], Q-1}: 01 adds the multiplicand, 10 subtracts it.
  localparam logic [1:0] M_ADD = 2'b01;
  localparam logic [1:0] M_SUB = 2'b10;

  typedef struct packed {
    logic clr_a;
    logic ld_b;
    logic add;
    logic sub;
    logic shift;
  } strobe_t;

  function automatic logic is_nop(input logic [1:0] m);
    return m[1] == m[0];
  endfunction

endpackage

// File: rtl/booth_mult_sequencer_rise_detect.sv
// Rising-edge detector for an already-synchronized level.
// The delayed copy is updated every cycle regardless of what consumes the edge.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic level_q;

  // NOTE: asynchronous reset in the sensitivity list; the flop clears without waiting for clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/booth_mult_sequencer.sv
// Control FSM for the radix-2 Booth multiplier: clears/loads the datapath, then
// alternates EVAL (add/sub/none) and SHIFT for N_BITS iterations per Run press.
module booth_mult_sequencer #(
  parameter  int N_BITS   = 8,
  parameter  bit SKIP_NOP = 1'b0,
  localparam int CNT_W    = $clog2(N_BITS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             clear_load,
  input  logic             accumulate,
  input  logic [1:0]       m_pair,
  output logic             clr_a,
  output logic             ld_b,
  output logic             add,
  output logic             sub,
  output logic             shift,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] step_cnt
);

  import booth_pkg::*;

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [CNT_W-1:0] step_nxt;
  strobe_t          stb;
  logic             run_rise;
  logic             last_step;

  rise_detect u_run_edge (
    .clk   (clk),
    .reset (reset),
    .level (run),
    .rise  (run_rise)
  );

  assign last_step = (step_cnt == CNT_W'(N_BITS - 1));

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      step_cnt <= '0;
    end else begin
      state    <= state_nxt;
      step_cnt <= step_nxt;
    end
  end

  // NOTE: every variable gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    step_nxt  = step_cnt;
    stb       = '0;
    case (state)
      IDLE: begin
        // Clear_Load has priority; a simultaneous Run edge is dropped.
        if (clear_load) begin
          stb.clr_a = 1'b1;
          stb.ld_b  = 1'b1;
        end else if (run_rise) begin
          state_nxt = accumulate ? EVAL : CLEAR;
          step_nxt  = '0;
        end
      end
      CLEAR: begin
        stb.clr_a = 1'b1;
        state_nxt = EVAL;
      end
      EVAL: begin
        // With SKIP_NOP a 00/11 pair shifts immediately instead of idling a cycle.
        if (SKIP_NOP && is_nop(m_pair)) begin
          stb.shift = 1'b1;
          step_nxt  = step_cnt + CNT_W'(1);
          state_nxt = last_step ? DONE : EVAL;
        end else begin
          stb.add   = (m_pair == M_ADD);
          stb.sub   = (m_pair == M_SUB);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        stb.shift = 1'b1;
        step_nxt  = step_cnt + CNT_W'(1);
        state_nxt = last_step ? DONE : EVAL;
      end
      DONE: begin
        if (!run) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Gating with reset keeps the IDLE Clear_Load strobes low while reset is held.
  assign clr_a = stb.clr_a & ~reset;
  assign ld_b  = stb.ld_b  & ~reset;
  assign add   = stb.add   & ~reset;
  assign sub   = stb.sub   & ~reset;
  assign shift = stb.shift & ~reset;
  assign busy  = (state == CLEAR) || (state == EVAL) || (state == SHIFT);
  assign done  = (state == DONE);

endmodule
